// File: rtl/acc_tern_quant.sv
// Accumulate-and-quantize stage: sums cfg_len signed partial sums per neuron and emits a ternary
// activation plus the raw sum. Define ACC_SAT_EN for saturating accumulation (default: wrap-around).
module acc_tern_quant #(
  parameter int data_in_width = 32,
  parameter int len_width     = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic [len_width-1:0]     cfg_len,
  input  logic [data_in_width-1:0] cfg_th_pos,
  input  logic [data_in_width-1:0] cfg_th_neg,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [data_in_width-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_trit,
  output logic [data_in_width-1:0] out_acc
);

  typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

  localparam logic [len_width:0] cnt_one = {{len_width{1'b0}}, 1'b1};

  state_t                          state, state_nxt;
  logic signed [data_in_width-1:0] acc, th_pos_q, th_neg_q;
  logic signed [data_in_width-1:0] sum, acc_nxt, th_pos_use, th_neg_use;
  logic [len_width:0]              cnt, len_q, len_eff;
  logic                            accept, last;
  logic [1:0]                      trit_nxt;

  // in_ready depends only on the state register, never on in_valid/out_ready.
  assign in_ready = (state != OUT);
  assign accept   = in_valid & in_ready;
  assign len_eff  = (cfg_len == '0) ? cnt_one : {1'b0, cfg_len};

`ifdef ACC_SAT_EN
  logic signed [data_in_width-1:0] raw_sum;
  logic                            ovf;
  always_comb begin
    raw_sum = acc + $signed(in_data);
    ovf     = (acc[data_in_width-1] == in_data[data_in_width-1]) &&
              (raw_sum[data_in_width-1] != acc[data_in_width-1]);
    if (!ovf)                        sum = raw_sum;
    else if (acc[data_in_width-1])   sum = {1'b1, {(data_in_width-1){1'b0}}};
    else                             sum = {1'b0, {(data_in_width-1){1'b1}}};
  end
`else
  assign sum = acc + $signed(in_data);
`endif

  // The first beat of a neuron uses the live config, since the latched copy is written on that same edge.
  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    acc_nxt    = sum;
    last       = (cnt + cnt_one == len_q);
    th_pos_use = th_pos_q;
    th_neg_use = th_neg_q;
    if (state == IDLE) begin
      acc_nxt    = $signed(in_data);
      last       = (len_eff == cnt_one);
      th_pos_use = $signed(cfg_th_pos);
      th_neg_use = $signed(cfg_th_neg);
    end
    if (acc_nxt > th_pos_use)      trit_nxt = 2'b01;
    else if (acc_nxt < th_neg_use) trit_nxt = 2'b11;
    else                           trit_nxt = 2'b00;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = last ? OUT : ACC;
      ACC:     if (accept && last) state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (clr) state_nxt = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      th_pos_q  <= '0;
      th_neg_q  <= '0;
      out_valid <= 1'b0;
      out_trit  <= 2'b00;
      out_acc   <= '0;
    end else if (clr) begin
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_nxt;
        cnt <= (state == IDLE) ? cnt_one : cnt + cnt_one;
        if (state == IDLE) begin
          len_q    <= len_eff;
          th_pos_q <= $signed(cfg_th_pos);
          th_neg_q <= $signed(cfg_th_neg);
        end
        if (last) begin
          out_valid <= 1'b1;
          out_trit  <= trit_nxt;
          out_acc   <= acc_nxt;
        end
      end
      if (state == OUT && out_ready) out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_acc_tern_quant.sv
// Self-checking bench for acc_tern_quant: directed cases plus randomized neurons against an
// arithmetic reference model (honours ACC_SAT_EN the same way the design does).
module tb_acc_tern_quant;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clr;
  logic [7:0]  cfg_len;
  logic [31:0] cfg_th_pos, cfg_th_neg;
  logic        in_valid, in_ready;
  logic [31:0] in_data;
  logic        out_valid, out_ready;
  logic [1:0]  out_trit;
  logic [31:0] out_acc;

  int total = 0;
  int bad   = 0;
  int beats[$];

  acc_tern_quant dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .cfg_len(cfg_len),
    .cfg_th_pos(cfg_th_pos), .cfg_th_neg(cfg_th_neg),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_trit(out_trit), .out_acc(out_acc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Exact integer sum, then wrap to 32 bits or clamp to the signed range after every addition.
  function automatic int model_sum();
    longint s = 0;
    foreach (beats[i]) begin
      s += longint'(beats[i]);
`ifdef ACC_SAT_EN
      if (s > 64'sd2147483647)  s = 64'sd2147483647;
      if (s < -64'sd2147483648) s = -64'sd2147483648;
`else
      s = longint'(int'(s));
`endif
    end
    return int'(s);
  endfunction

  function automatic logic [1:0] model_trit(input int s, input int thp, input int thn);
    if (s > thp)      return 2'b01;
    else if (s < thn) return 2'b11;
    else              return 2'b00;
  endfunction

  // Presents one beat in the next cycle; config is live only on the first beat, garbage afterwards.
  task automatic drive_beat(input int d, input bit first, input int len_cfg, input int thp, input int thn);
    @(negedge clk);
    cfg_len    = first ? 8'(len_cfg) : 8'($urandom);
    cfg_th_pos = first ? thp : $urandom;
    cfg_th_neg = first ? thn : $urandom;
    in_valid   = 1'b1;
    in_data    = d;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_neuron(input string tag, input int len_cfg, input int thp, input int thn,
                            input int stall);
    int          exp_s;
    logic [1:0]  exp_t;
    foreach (beats[i]) drive_beat(beats[i], i == 0, len_cfg, thp, thn);
    exp_s = model_sum();
    exp_t = model_trit(exp_s, thp, thn);
    @(negedge clk);
    check({tag, ".valid"}, 32'(out_valid), 32'd1);
    check({tag, ".acc"},   out_acc, exp_s);
    check({tag, ".trit"},  32'(out_trit), 32'(exp_t));
    check({tag, ".ready"}, 32'(in_ready), 32'd0);
    for (int k = 0; k < stall; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(negedge clk);
      check({tag, ".hold"}, {out_valid, in_ready, out_trit, out_acc[27:0]},
            {1'b1, 1'b0, exp_t, exp_s[27:0]});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".done"}, {30'd0, out_valid, in_ready}, 32'b01);
    check({tag, ".kept"}, out_acc, exp_s);
  endtask

  initial begin
    int len;
    rst_n = 1'b0; clr = 1'b0; cfg_len = '0; cfg_th_pos = '0; cfg_th_neg = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check("reset", {27'd0, in_ready, out_valid, out_trit, out_acc[0]}, 32'b10000);
    check("reset.acc", out_acc, 32'd0);

    beats = '{3, 4, 5, 6};
    run_neuron("len4", 4, 10, -10, 2);
    check("len4.const", out_acc, 32'd18);
    beats = '{-20};
    run_neuron("len0", 0, 10, -10, 0);
    beats = '{-20};
    run_neuron("len1", 1, 10, -10, 1);
    check("len1.const", out_acc, 32'hFFFF_FFEC);
    beats = '{10, -5, -5};
    run_neuron("zero", 3, 1, -1, 5);
    beats = '{50};
    run_neuron("thprio", 1, 0, 100, 0);
    beats = '{int'(32'h7FFF_FFFF), 1};
    run_neuron("ovf_pos", 2, 0, 0, 0);
`ifdef ACC_SAT_EN
    check("ovf_pos.const", out_acc, 32'h7FFF_FFFF);
`else
    check("ovf_pos.const", out_acc, 32'h8000_0000);
`endif
    beats = '{int'(32'h8000_0000), -1, int'(32'h8000_0000)};
    run_neuron("ovf_neg", 3, 0, 0, 0);

    // Soft clear mid-neuron: the beat presented with clr is dropped.
    drive_beat(100, 1'b1, 4, 0, 0);
    drive_beat(200, 1'b0, 4, 0, 0);
    @(negedge clk);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'd999;
    @(posedge clk);
    #1 clr = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("clr.state", {30'd0, out_valid, in_ready}, 32'b01);
    beats = '{1, 1, 1, 1};
    run_neuron("after_clr", 4, 2, -2, 0);
    check("after_clr.const", out_acc, 32'd4);

    // Asynchronous reset mid-neuron, checked between clock edges.
    drive_beat(7, 1'b1, 4, 0, 0);
    drive_beat(8, 1'b0, 4, 0, 0);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check("rst_mid", {out_valid, in_ready, out_trit, out_acc[27:0]}, 32'h4000_0000);
    #1 rst_n = 1'b1;
    drive_beat(7, 1'b1, 1, 0, 0);
    @(negedge clk);
    check("rst_out.pre", {out_valid, out_acc[30:0]}, 32'h8000_0007);
    #1 rst_n = 1'b0;
    #1 check("rst_out", {out_valid, in_ready, out_trit, out_acc[27:0]}, 32'h4000_0000);
    #1 rst_n = 1'b1;
    beats = '{5, -2, 9};
    run_neuron("post_rst", 3, 11, 0, 0);

    beats = {};
    for (int i = 0; i < 255; i++) beats.push_back(int'($urandom_range(0, 20)) - 10);
    run_neuron("len255", 255, 5, -5, 0);

    for (int n = 0; n < 25; n++) begin
      int thp, thn, cfg;
      cfg = $urandom_range(0, 6);
      len = (cfg == 0) ? 1 : cfg;
      thp = int'($urandom_range(0, 200)) - 100;
      thn = int'($urandom_range(0, 200)) - 100;
      beats = {};
      for (int i = 0; i < len; i++)
        beats.push_back((n % 4 == 3) ? int'($urandom) : int'($urandom_range(0, 80)) - 40);
      run_neuron("rand", cfg, thp, thn, $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
